sd_sector_range_dumper: RTL and testbench

//  Sequencer that reads NUM_SECTORS consecutive SD sectors starting at START_SECTOR through
//  sd_spi_sector_reader, and streams every byte to uart_tx. Output is raw bytes or ASCII hex.

---
 rtl/sd_sector_range_dumper.sv | 151 +++++++++++++++
 tb/tb_sd_sector_range_dumper.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sd_sector_range_dumper.sv
// Reads a range of SD sectors through the SPI sector reader, buffers each 512-byte sector,
// and streams it to the UART as raw bytes or as an ASCII hex dump.
module sd_sector_range_dumper #(
    parameter logic [31:0] START_SECTOR   = 32'd0,
    parameter int          NUM_SECTORS    = 4,
    parameter bit          HEX_MODE       = 1'b1,
    parameter int          BYTES_PER_LINE = 16,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        CLK100MHZ,
    input  logic        RESETN,
    input  logic        start,
    output logic        rd_start,
    output logic [31:0] rd_sector_no,
    input  logic        rd_done,
    input  logic        rd_rvalid,
    input  logic [7:0]  rd_rdata,
    output logic        tx_wreq,
    input  logic        tx_wgnt,
    output logic [7:0]  tx_wdata,
    output logic        busy,
    output logic        run_done,
    output logic        err
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_FETCH, S_DUMP} state_t;

    localparam logic [8:0]  LINE_MASK = 9'(BYTES_PER_LINE - 1);
    localparam logic [31:0] LAST_SEC  = 32'(NUM_SECTORS - 1);

    state_t      state;
    logic [7:0]  sbuf [0:511];
    logic [7:0]  buf_q;
    logic [9:0]  wr_cnt, cnt_nxt;
    logic [8:0]  byte_idx;
    logic [1:0]  phase, nxt_phase;
    logic [31:0] sec_idx;
    logic        pend;
    logic        line_end, last_char;
    logic [7:0]  cur_char, nxt_char;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    // Hex phases per byte: high nibble, low nibble, space or CR, LF (line end only)
    function automatic logic [7:0] char_at(input logic [7:0] d, input logic [1:0] ph,
                                           input logic le);
        if (!HEX_MODE) return d;
        case (ph)
            2'd0:    return hex_char(d[7:4]);
            2'd1:    return hex_char(d[3:0]);
            2'd2:    return le ? 8'h0D : 8'h20;
            default: return 8'h0A;
        endcase
    endfunction

    // Sector buffer: no reset, registered read port
    always_ff @(posedge CLK100MHZ) begin
        if (state == S_READ && rd_rvalid && !wr_cnt[9])
            sbuf[wr_cnt[8:0]] <= rd_rdata;
        buf_q <= sbuf[byte_idx];
    end

    always_comb begin
        line_end  = (byte_idx & LINE_MASK) == LINE_MASK;
        cnt_nxt   = wr_cnt + {9'd0, rd_rvalid & ~&wr_cnt};
        last_char = !HEX_MODE || (phase == 2'd3) || (phase == 2'd2 && !line_end);
        nxt_phase = phase + 2'd1;
        cur_char  = char_at(buf_q, phase, line_end);
        nxt_char  = char_at(buf_q, nxt_phase, line_end);
    end

    always_ff @(posedge CLK100MHZ or negedge RESETN) begin
        if (!RESETN) begin
            state        <= S_IDLE;
            rd_start     <= 1'b0;
            rd_sector_no <= START_SECTOR;
            tx_wreq      <= 1'b0;
            tx_wdata     <= 8'h00;
            busy         <= 1'b0;
            run_done     <= 1'b0;
            err          <= 1'b0;
            wr_cnt       <= 10'd0;
            byte_idx     <= 9'd0;
            phase        <= 2'd0;
            sec_idx      <= 32'd0;
            pend         <= AUTO_START;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start || pend) begin
                        pend         <= 1'b0;
                        run_done     <= 1'b0;
                        err          <= 1'b0;
                        busy         <= 1'b1;
                        sec_idx      <= 32'd0;
                        rd_sector_no <= START_SECTOR;
                        wr_cnt       <= 10'd0;
                        rd_start     <= 1'b1;
                        state        <= S_READ;
                    end
                end
                S_READ: begin
                    wr_cnt <= cnt_nxt;
                    if (rd_done) begin
                        rd_start <= 1'b0;
                        if (cnt_nxt == 10'd512) begin
                            byte_idx <= 9'd0;
                            phase    <= 2'd0;
                            state    <= S_FETCH;
                        end else begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end
                S_FETCH: state <= S_DUMP;
                S_DUMP: begin
                    if (!tx_wreq) begin
                        tx_wreq  <= 1'b1;
                        tx_wdata <= cur_char;
                    end else if (tx_wgnt) begin
                        if (!last_char) begin
                            phase    <= nxt_phase;
                            tx_wdata <= nxt_char;
                        end else begin
                            tx_wreq <= 1'b0;
                            phase   <= 2'd0;
                            if (byte_idx != 9'd511) begin
                                byte_idx <= byte_idx + 9'd1;
                                state    <= S_FETCH;
                            end else if (sec_idx == LAST_SEC) begin
                                run_done <= 1'b1;
                                busy     <= 1'b0;
                                state    <= S_IDLE;
                            end else begin
                                sec_idx      <= sec_idx + 32'd1;
                                rd_sector_no <= rd_sector_no + 32'd1;
                                wr_cnt       <= 10'd0;
                                rd_start     <= 1'b1;
                                state        <= S_READ;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_sector_range_dumper.sv
// Directed bench: a hex-mode 3-sector instance with wrapping sector numbers and a raw
// auto-start 1-sector instance, each driven by a small reader model and UART sink.
module tb_sd_sector_range_dumper;
    logic CLK100MHZ = 1'b0;
    logic RESETN    = 1'b0;
    always #5 CLK100MHZ = ~CLK100MHZ;

    logic        a_start, a_rd_start, a_rd_done, a_rd_rvalid, a_tx_wreq, a_tx_wgnt;
    logic        a_busy, a_run_done, a_err;
    logic [31:0] a_rd_sector_no;
    logic [7:0]  a_rd_rdata, a_tx_wdata;
    logic        b_start, b_rd_start, b_rd_done, b_rd_rvalid, b_tx_wreq, b_tx_wgnt;
    logic        b_busy, b_run_done, b_err;
    logic [31:0] b_rd_sector_no;
    logic [7:0]  b_rd_rdata, b_tx_wdata;

    sd_sector_range_dumper #(.START_SECTOR(32'hFFFF_FFFE), .NUM_SECTORS(3), .HEX_MODE(1'b1),
                             .BYTES_PER_LINE(16), .AUTO_START(1'b0)) dut_a (
        .CLK100MHZ(CLK100MHZ), .RESETN(RESETN), .start(a_start),
        .rd_start(a_rd_start), .rd_sector_no(a_rd_sector_no), .rd_done(a_rd_done),
        .rd_rvalid(a_rd_rvalid), .rd_rdata(a_rd_rdata), .tx_wreq(a_tx_wreq),
        .tx_wgnt(a_tx_wgnt), .tx_wdata(a_tx_wdata), .busy(a_busy),
        .run_done(a_run_done), .err(a_err));

    sd_sector_range_dumper #(.START_SECTOR(32'd0), .NUM_SECTORS(1), .HEX_MODE(1'b0),
                             .BYTES_PER_LINE(16), .AUTO_START(1'b1)) dut_b (
        .CLK100MHZ(CLK100MHZ), .RESETN(RESETN), .start(b_start),
        .rd_start(b_rd_start), .rd_sector_no(b_rd_sector_no), .rd_done(b_rd_done),
        .rd_rvalid(b_rd_rvalid), .rd_rdata(b_rd_rdata), .tx_wreq(b_tx_wreq),
        .tx_wgnt(b_tx_wgnt), .tx_wdata(b_tx_wdata), .busy(b_busy),
        .run_done(b_run_done), .err(b_err));

    int n_chk = 0, n_err = 0;
    int a_nbytes = 512, a_starts = 0, b_starts = 0, a_unstable = 0, gcyc = 0;
    bit a_gslow = 1'b0, a_hold = 1'b0;
    logic [7:0]  a_hold_d;
    logic [7:0]  a_q[$], b_q[$];
    logic [31:0] a_secs[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reader models: answer each rd_start with a sector, then a done pulse
    initial begin
        a_rd_rvalid = 1'b0; a_rd_done = 1'b0; a_rd_rdata = 8'h00;
        forever begin
            @(posedge CLK100MHZ); #1;
            if (a_rd_start) begin
                a_starts++;
                a_secs.push_back(a_rd_sector_no);
                for (int i = 0; i < a_nbytes; i++) begin
                    a_rd_rvalid = 1'b1; a_rd_rdata = 8'(i & 15);
                    @(posedge CLK100MHZ); #1;
                end
                a_rd_rvalid = 1'b0; a_rd_done = 1'b1;
                @(posedge CLK100MHZ); #1;
                a_rd_done = 1'b0;
            end
        end
    end

    initial begin
        b_rd_rvalid = 1'b0; b_rd_done = 1'b0; b_rd_rdata = 8'h00;
        forever begin
            @(posedge CLK100MHZ); #1;
            if (b_rd_start) begin
                b_starts++;
                for (int i = 0; i < 512; i++) begin
                    b_rd_rvalid = 1'b1; b_rd_rdata = 8'(i);
                    @(posedge CLK100MHZ); #1;
                end
                b_rd_rvalid = 1'b0; b_rd_done = 1'b1;
                @(posedge CLK100MHZ); #1;
                b_rd_done = 1'b0;
            end
        end
    end

    initial begin
        a_tx_wgnt = 1'b1; b_tx_wgnt = 1'b1;
        forever begin
            @(posedge CLK100MHZ); #1;
            gcyc++;
            a_tx_wgnt = a_gslow ? (gcyc % 4 == 0) : 1'b1;
        end
    end

    // UART sinks plus hold-stability watch on instance A
    always @(negedge CLK100MHZ) begin
        if (a_tx_wreq && a_tx_wgnt) a_q.push_back(a_tx_wdata);
        if (b_tx_wreq && b_tx_wgnt) b_q.push_back(b_tx_wdata);
        if (a_hold && (!a_tx_wreq || a_tx_wdata !== a_hold_d)) a_unstable++;
        a_hold   = a_tx_wreq && !a_tx_wgnt;
        a_hold_d = a_tx_wdata;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic pulse_a_start();
        a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
    endtask

    task automatic wait_a_idle(input int maxc, input string tag);
        int n = 0;
        while (a_busy && n < maxc) begin tick(1); n++; end
        check(tag, 32'(a_busy), 32'd0);
    endtask

    task automatic wait_a_chars(input int target, input int maxc, input string tag);
        int n = 0;
        while (a_q.size() < target && n < maxc) begin tick(1); n++; end
        check(tag, 32'(a_q.size() >= target), 32'd1);
    endtask

    task automatic check_a_reset(input string pfx);
        check({pfx, "_rd_start"}, 32'(a_rd_start), 32'd0);
        check({pfx, "_wreq"},     32'(a_tx_wreq),  32'd0);
        check({pfx, "_busy"},     32'(a_busy),     32'd0);
        check({pfx, "_run_done"}, 32'(a_run_done), 32'd0);
        check({pfx, "_err"},      32'(a_err),      32'd0);
        check({pfx, "_sector"},   a_rd_sector_no,  32'hFFFF_FFFE);
        check({pfx, "_wdata"},    32'(a_tx_wdata), 32'd0);
    endtask

    initial begin
        string hx = "0123456789ABCDEF";
        logic [7:0] exp_q[$];
        int mism, qsz, n;
        a_start = 1'b0; b_start = 1'b0;

        tick(3);
        check_a_reset("rst");
        check("rst_b_busy", 32'(b_busy), 32'd0);
        RESETN = 1'b1;
        tick(5);
        check("no_auto_a", 32'(a_busy), 32'd0);
        check("auto_b", 32'(b_busy), 32'd1);

        // Raw single-sector run on B
        n = 0;
        while (b_busy && n < 5000) begin tick(1); n++; end
        check("b_idle", 32'(b_busy), 32'd0);
        check("b_run_done", 32'(b_run_done), 32'd1);
        check("b_err", 32'(b_err), 32'd0);
        check("b_chars", b_q.size(), 32'd512);
        mism = 0;
        foreach (b_q[i]) if (b_q[i] !== 8'(i)) mism++;
        check("b_data", mism, 32'd0);
        check("b_starts", b_starts, 32'd1);

        // Hex 3-sector run on A with slow grant and an ignored mid-run start
        a_gslow = 1'b1;
        pulse_a_start();
        check("a_busy_run1", 32'(a_busy), 32'd1);
        wait_a_chars(100, 3000, "a_mid_wait");
        pulse_a_start();
        wait_a_idle(40000, "a_run1_idle");
        check("a_run_done", 32'(a_run_done), 32'd1);
        check("a_err_run1", 32'(a_err), 32'd0);
        check("a_chars", a_q.size(), 32'd4704);
        check("a_c0", 32'(a_q[0]), 32'h30);
        check("a_c2", 32'(a_q[2]), 32'h20);
        check("a_c45", 32'(a_q[45]), 32'h30);
        check("a_c46", 32'(a_q[46]), 32'h46);
        check("a_c47", 32'(a_q[47]), 32'h0D);
        check("a_c48", 32'(a_q[48]), 32'h0A);
        check("a_c49", 32'(a_q[49]), 32'h30);
        for (int s = 0; s < 3; s++)
            for (int b = 0; b < 512; b++) begin
                exp_q.push_back(8'h30);
                exp_q.push_back(hx[b % 16]);
                if (b % 16 == 15) begin exp_q.push_back(8'h0D); exp_q.push_back(8'h0A); end
                else exp_q.push_back(8'h20);
            end
        mism = 0;
        foreach (exp_q[i]) if (i >= a_q.size() || a_q[i] !== exp_q[i]) mism++;
        check("a_stream", mism, 32'd0);
        check("a_stable", a_unstable, 32'd0);
        check("a_sec0", a_secs[0], 32'hFFFF_FFFE);
        check("a_sec1", a_secs[1], 32'hFFFF_FFFF);
        check("a_sec2", a_secs[2], 32'h0000_0000);
        tick(50);
        check("a_starts_run1", a_starts, 32'd3);
        check("a_no_extra", 32'(a_busy), 32'd0);

        // Short sector aborts the run
        a_gslow = 1'b0;
        a_nbytes = 511;
        qsz = a_q.size();
        pulse_a_start();
        wait_a_idle(3000, "a_short_idle");
        check("a_short_err", 32'(a_err), 32'd1);
        check("a_short_done", 32'(a_run_done), 32'd0);
        check("a_short_chars", a_q.size(), qsz);
        check("a_short_sec", a_secs[3], 32'hFFFF_FFFE);

        // Next start clears err; reset mid-dump with a start pulse while busy
        a_nbytes = 512;
        pulse_a_start();
        tick(1);
        check("a_err_clr", 32'(a_err), 32'd0);
        check("a_busy_run3", 32'(a_busy), 32'd1);
        wait_a_chars(qsz + 20, 3000, "a_dump_wait");
        pulse_a_start();
        RESETN = 1'b0;
        #2;
        check_a_reset("mid");
        qsz = a_q.size();
        tick(3);
        RESETN = 1'b1;
        tick(50);
        check("a_post_busy", 32'(a_busy), 32'd0);
        check("a_post_chars", a_q.size(), qsz);
        check("a_post_starts", a_starts, 32'd5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
